// File: rtl/mc_pkg.sv
// Shared definitions for the RV32I multi-cycle control sequencer:
// opcode classes, FSM state encoding and datapath select codes.
package mc_pkg;

    localparam int unsigned OPC_W = 7;
    localparam int unsigned F3_W  = 3;
    localparam int unsigned SEL_W = 2;

    localparam logic [OPC_W-1:0] OP_R      = 7'b0110011;
    localparam logic [OPC_W-1:0] OP_I      = 7'b0010011;
    localparam logic [OPC_W-1:0] OP_LOAD   = 7'b0000011;
    localparam logic [OPC_W-1:0] OP_STORE  = 7'b0100011;
    localparam logic [OPC_W-1:0] OP_BRANCH = 7'b1100011;
    localparam logic [OPC_W-1:0] OP_JAL    = 7'b1101111;
    localparam logic [OPC_W-1:0] OP_JALR   = 7'b1100111;
    localparam logic [OPC_W-1:0] OP_LUI    = 7'b0110111;
    localparam logic [OPC_W-1:0] OP_AUIPC  = 7'b0010111;
    localparam logic [OPC_W-1:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        HALT   = 3'd6,
        ERR    = 3'd7
    } state_e;

    localparam logic [SEL_W-1:0] PC_SEL_PLUS4 = 2'd0;
    localparam logic [SEL_W-1:0] PC_SEL_IMM   = 2'd1;
    localparam logic [SEL_W-1:0] PC_SEL_JALR  = 2'd2;

    localparam logic [SEL_W-1:0] WB_SEL_ALU   = 2'd0;
    localparam logic [SEL_W-1:0] WB_SEL_MDR   = 2'd1;
    localparam logic [SEL_W-1:0] WB_SEL_PC4   = 2'd2;

    // Only EBREAK (funct3 = 0) is accepted from the SYSTEM class.
    function automatic logic op_legal(input logic [OPC_W-1:0] op,
                                      input logic [F3_W-1:0]  f3);
        logic ok;
        ok = 1'b0;
        case (op)
            OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH,
            OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: ok = 1'b1;
            OP_SYSTEM:                         ok = (f3 == 3'd0);
            default:                           ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mc_perf_cnt.sv
// Free-running cycle counter and retired-instruction counter, both wrapping.
module mc_perf_cnt #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cyc_en,
    input  logic             ret_en,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
);

    logic [CNT_W-1:0] cyc_q, cyc_d;
    logic [CNT_W-1:0] ret_q, ret_d;

    always_comb begin
        cyc_d = cyc_q;
        ret_d = ret_q;
        if (cyc_en) cyc_d = cyc_q + CNT_W'(1);
        if (ret_en) ret_d = ret_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cyc_q <= '0;
            ret_q <= '0;
        end else begin
            cyc_q <= cyc_d;
            ret_q <= ret_d;
        end
    end

    assign cycle_cnt   = cyc_q;
    assign instret_cnt = ret_q;

endmodule

// File: rtl/mc_ctrl_seq.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer driving the shared RV32I
// datapath strobes, with req/ack memory handshakes and an ack timeout.
module mc_ctrl_seq
    import mc_pkg::*;
#(
    parameter int unsigned CNT_W    = 32,
    parameter int unsigned WAIT_MAX = 15,
    parameter int unsigned WAIT_W   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [OPC_W-1:0] opcode,
    input  logic [F3_W-1:0]  funct3,
    input  logic             br_taken,
    input  logic             imem_ack,
    input  logic             dmem_ack,
    output logic             imem_req,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             ir_we,
    output logic             ab_we,
    output logic             alu_we,
    output logic             mdr_we,
    output logic             rf_we,
    output logic             pc_we,
    output logic [SEL_W-1:0] pc_sel,
    output logic [SEL_W-1:0] wb_sel,
    output logic             halted,
    output logic             err,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
);

    localparam bit TMO_EN = (WAIT_MAX != 0);

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              halted_q, halted_d;
    logic              err_q, err_d;
    logic              timeout_c;
    logic              is_load_c, is_store_c;

    assign is_load_c  = (opcode == OP_LOAD);
    assign is_store_c = (opcode == OP_STORE);
    // An ack in the same cycle always takes priority over this.
    assign timeout_c  = TMO_EN && (wait_q == WAIT_W'(WAIT_MAX));

    // Next-state and strobe decode; wait counter defaults to clear so it
    // restarts on every entry to FETCH/MEM and after every ack.
    always_comb begin
        state_d  = state_q;
        wait_d   = '0;
        imem_req = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        ir_we    = 1'b0;
        ab_we    = 1'b0;
        alu_we   = 1'b0;
        mdr_we   = 1'b0;
        rf_we    = 1'b0;
        pc_we    = 1'b0;
        pc_sel   = PC_SEL_PLUS4;
        wb_sel   = WB_SEL_ALU;

        case (state_q)
            IDLE: state_d = FETCH;
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_we   = 1'b1;
                    state_d = DECODE;
                end else if (timeout_c) begin
                    state_d = ERR;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            DECODE: begin
                ab_we = 1'b1;
                if (!op_legal(opcode, funct3)) state_d = ERR;
                else if (opcode == OP_SYSTEM)  state_d = HALT;
                else                           state_d = EXEC;
            end
            EXEC: begin
                alu_we = 1'b1;
                if (is_load_c || is_store_c) begin
                    state_d = MEM;
                end else if (opcode == OP_BRANCH) begin
                    pc_we   = 1'b1;
                    pc_sel  = br_taken ? PC_SEL_IMM : PC_SEL_PLUS4;
                    state_d = FETCH;
                end else begin
                    state_d = WB;
                end
            end
            MEM: begin
                dmem_req = 1'b1;
                dmem_we  = is_store_c;
                if (dmem_ack) begin
                    if (is_store_c) begin
                        pc_we   = 1'b1;
                        state_d = FETCH;
                    end else begin
                        mdr_we  = 1'b1;
                        state_d = WB;
                    end
                end else if (timeout_c) begin
                    state_d = ERR;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            WB: begin
                rf_we   = 1'b1;
                pc_we   = 1'b1;
                state_d = FETCH;
                case (opcode)
                    OP_JAL: begin
                        pc_sel = PC_SEL_IMM;
                        wb_sel = WB_SEL_PC4;
                    end
                    OP_JALR: begin
                        pc_sel = PC_SEL_JALR;
                        wb_sel = WB_SEL_PC4;
                    end
                    OP_LOAD: wb_sel = WB_SEL_MDR;
                    default: ;
                endcase
            end
            HALT:    state_d = HALT;
            ERR:     state_d = ERR;
            default: state_d = IDLE;
        endcase

        halted_d = halted_q | (state_d == HALT);
        err_d    = err_q | (state_d == ERR);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            wait_q   <= '0;
            halted_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wait_q   <= wait_d;
            halted_q <= halted_d;
            err_q    <= err_d;
        end
    end

    assign halted = halted_q;
    assign err    = err_q;

    // Every PC update is a retirement; EBREAK and illegal never reach one.
    mc_perf_cnt #(
        .CNT_W (CNT_W)
    ) u_perf_cnt (
        .clk         (clk),
        .rst         (rst),
        .cyc_en      (1'b1),
        .ret_en      (pc_we),
        .cycle_cnt   (cycle_cnt),
        .instret_cnt (instret_cnt)
    );

endmodule

// File: doc/mc_ctrl_seq.md
Name: mc_ctrl_seq

Overview:
Multi-cycle control sequencer for the RV32I core. It replaces the single-cycle datapath's "everything in one clock" timing with a FETCH/DECODE/EXEC/MEM/WB state machine. It talks to instruction and data memories through req/ack handshakes with a parametrised timeout, and maintains cycle and retired-instruction counters. It drives the enables and selects of a shared datapath: PC, IR, A/B latches, ALU-out, MDR and RF.

Parameters:
CNT_W, 32, width of cycle_cnt and instret_cnt (wrap on overflow)
WAIT_MAX, 15, max wait cycles for imem/dmem ack before error; 0 disables timeout
WAIT_W, 4, width of wait counter; must hold WAIT_MAX

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-low reset
opcode  in  7  ins[6:0] from IR
funct3  in  3  ins[14:12] from IR
br_taken  in  1  branch condition from ALU compare, valid in EXEC
imem_ack  in  1  instruction word valid this cycle
dmem_ack  in  1  data access complete this cycle
imem_req  out  1  instruction fetch request
dmem_req  out  1  data access request
dmem_we  out  1  data write (store), qualified by dmem_req
ir_we  out  1  load IR
ab_we  out  1  latch rs1/rs2/imm into A/B
alu_we  out  1  latch ALU result
mdr_we  out  1  latch load data
rf_we  out  1  register file write
pc_we  out  1  PC update
pc_sel  out  2  0 pc+4, 1 pc+imm, 2 alu_out & ~1
wb_sel  out  2  0 alu_out, 1 mdr, 2 pc+4
halted  out  1  EBREAK executed, sticky
err  out  1  illegal opcode or memory timeout, sticky
cycle_cnt  out  CNT_W  cycles since reset
instret_cnt  out  CNT_W  retired instructions

Behaviour:
- Reset (rst=0, async): state=IDLE, wait counter=0, counters=0, halted=err=0, every output 0. IDLE->FETCH unconditionally on the first edge after release.
- All strobes are combinational from state plus ack/br_taken (Mealy on ack only). All are 0 in IDLE, HALT and ERR.
- Opcode classes: R 0110011, I 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111, SYSTEM 1110011 (funct3=0 treated as EBREAK). Anything else is illegal.
- FETCH: imem_req=1 held until ack. On imem_ack: ir_we=1, ->DECODE.
- DECODE: ab_we=1. Illegal ->ERR. SYSTEM ->HALT. Else ->EXEC.
- EXEC: alu_we=1.
  - LOAD/STORE ->MEM.
  - BRANCH: pc_we=1, pc_sel=br_taken?1:0, retire, ->FETCH.
  - All others ->WB.
- MEM: dmem_req=1, dmem_we=(STORE). Hold until dmem_ack.
  - LOAD: mdr_we=1 on ack, ->WB.
  - STORE: pc_we=1, pc_sel=0 on ack, retire, ->FETCH.
- WB: rf_we=1, pc_we=1, retire, ->FETCH. Selects by class:
  - JAL: pc_sel=1, wb_sel=2
  - JALR: pc_sel=2, wb_sel=2
  - LOAD: pc_sel=0, wb_sel=1
  - others: pc_sel=0, wb_sel=0
- Latency with zero-wait memory: R/I/LUI/AUIPC/JAL/JALR 4 cycles, LOAD 5, STORE 4, BRANCH 3.
- Wait counter:
  - cleared on entry to FETCH/MEM and on ack.
  - increments each cycle a req is pending without ack.
  - if WAIT_MAX!=0 and the counter equals WAIT_MAX with no ack that cycle ->ERR.
  - ack arriving on the WAIT_MAX cycle wins; no error.
- HALT/ERR: terminal until reset, no requests. halted/err are registered and set on entry. cycle_cnt still counts. instret does not count EBREAK/illegal.
- cycle_cnt: +1 every edge with rst=1, including IDLE, HALT and ERR.
- instret_cnt: +1 on each retiring pc_we edge. Both counters wrap modulo 2^CNT_W.
- Reset mid-access: requests drop immediately (async). No partial retire. Counters clear.

Decomposition:
- Shared package mc_pkg holds:
  - opcode class localparams (OP_R ... OP_SYSTEM)
  - the state enum (IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT, ERR)
  - PC_SEL_* and WB_SEL_* codes
- One natural sub-module: mc_perf_cnt, holding the two CNT_W counters with enable inputs.

Test Plan:
- Reset, then ADD (0110011) with imem_ack immediate:
  - sequence IDLE,FETCH,DECODE,EXEC,WB,FETCH
  - rf_we=1 and pc_we=1 in WB with wb_sel=0
  - instret_cnt=1 after 5 edges
- LW with dmem_ack delayed 3 cycles:
  - dmem_req held 4 cycles, dmem_we=0
  - mdr_we pulses once
  - WB has wb_sel=1
  - 8 cycles from FETCH to next FETCH
- BEQ twice, br_taken=1 then 0:
  - pc_we in EXEC with pc_sel=1 then 0
  - no rf_we
  - 3 cycles each, instret +2
- SW then JALR:
  - SW: dmem_we=1, retires in MEM
  - JALR: WB with pc_sel=2, wb_sel=2, rf_we=1
- imem_ack never asserted, WAIT_MAX=15:
  - err=1 after the timeout, all requests 0
  - cycle_cnt keeps counting
  - ack on the 15th wait cycle instead causes no error
- Opcode 0000000 -> ERR after DECODE. EBREAK -> halted=1, instret unchanged.
- rst pulled low mid-MEM: outputs 0 immediately, counters 0, restart at FETCH.
